// File: rtl/multi_port_circular_buffer_if.sv
// Purpose: bundles the enqueue, dequeue, flush and occupancy signals of the multi-port queue.
// Latency: none; wires only.
// Backpressure: the producer sees wr_accept; the consumer sees rd_valid and rd_popped.
// Ports: master drives flush/wr_num/wr_data/rd_num; slave (the buffer) returns
//        wr_accept, rd_data, rd_valid, rd_popped, count, free_slots, full, empty.
// Optional: MPCB_ERR_EN adds the sticky overflow_err / underflow_err flags.
interface multi_port_circular_buffer_if #(
    parameter type T           = logic [31:0],
    parameter int  DEPTH       = 16,
    parameter int  WRITE_PORTS = 2,
    parameter int  READ_PORTS  = 2
);
    localparam int PW  = $clog2(DEPTH) + 1;
    localparam int WNW = $clog2(WRITE_PORTS + 1);
    localparam int RNW = $clog2(READ_PORTS + 1);

    logic                          flush;
    logic [WNW-1:0]                wr_num;
    T     [WRITE_PORTS-1:0]        wr_data;
    logic                          wr_accept;
    logic [RNW-1:0]                rd_num;
    T     [READ_PORTS-1:0]         rd_data;
    logic [READ_PORTS-1:0]         rd_valid;
    logic [RNW-1:0]                rd_popped;
    logic [PW-1:0]                 count;
    logic [PW-1:0]                 free_slots;
    logic                          full;
    logic                          empty;
`ifdef MPCB_ERR_EN
    logic                          overflow_err;
    logic                          underflow_err;
`endif

    modport master (
        output flush, wr_num, wr_data, rd_num,
        input  wr_accept, rd_data, rd_valid, rd_popped, count, free_slots, full, empty
`ifdef MPCB_ERR_EN
        , input overflow_err, underflow_err
`endif
    );

    modport slave (
        input  flush, wr_num, wr_data, rd_num,
        output wr_accept, rd_data, rd_valid, rd_popped, count, free_slots, full, empty
`ifdef MPCB_ERR_EN
        , output overflow_err, underflow_err
`endif
    );
endinterface

// File: rtl/multi_port_circular_buffer.sv
// Purpose: in-order circular queue accepting up to WRITE_PORTS pushes and READ_PORTS pops per cycle.
// Latency: one cycle from write to visibility on rd_data; no bypass.
// Backpressure: a write group is accepted whole or not at all (free_slots >= wr_num); pops saturate at count.
// Ports: clk, reset (synchronous, active-high), bus (multi_port_circular_buffer_if.slave).
// Optional: define MPCB_ERR_EN for sticky overflow_err / underflow_err outputs.
module multi_port_circular_buffer #(
    parameter type T           = logic [31:0],
    parameter int  DEPTH       = 16,
    parameter int  WRITE_PORTS = 2,
    parameter int  READ_PORTS  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    multi_port_circular_buffer_if.slave   bus
);
    localparam int AW  = $clog2(DEPTH);
    localparam int PW  = AW + 1;
    localparam int WNW = $clog2(WRITE_PORTS + 1);
    localparam int RNW = $clog2(READ_PORTS + 1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] cnt;
    logic [PW-1:0] free_w;
    logic [PW-1:0] wr_num_x;
    logic [PW-1:0] rd_num_x;
    logic [PW-1:0] popped_x;
    logic          wr_ok;

    T storage [DEPTH];

    assign cnt      = wr_ptr - rd_ptr;
    assign free_w   = PW'(DEPTH) - cnt;
    assign wr_num_x = PW'(bus.wr_num);
    assign rd_num_x = PW'(bus.rd_num);

    // Acceptance looks only at registered occupancy: same-cycle pops give no credit.
    assign wr_ok    = (free_w >= wr_num_x);
    assign popped_x = (rd_num_x > cnt) ? cnt : rd_num_x;

    assign bus.wr_accept  = wr_ok;
    assign bus.rd_popped  = RNW'(popped_x);
    assign bus.count      = cnt;
    assign bus.free_slots = free_w;
    assign bus.full       = (cnt == PW'(DEPTH));
    assign bus.empty      = (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            rd_ptr <= rd_ptr + popped_x;
            if (wr_ok) begin
                wr_ptr <= wr_ptr + wr_num_x;
            end
        end
    end

    // Lane addresses wrap naturally in AW bits since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && wr_ok) begin
            for (int i = 0; i < WRITE_PORTS; i++) begin
                if (WNW'(i) < bus.wr_num) begin
                    storage[wr_ptr[AW-1:0] + AW'(i)] <= bus.wr_data[i];
                end
            end
        end
    end

    for (genvar g = 0; g < READ_PORTS; g++) begin : g_rd
        assign bus.rd_valid[g] = (PW'(g) < cnt);
        assign bus.rd_data[g]  = storage[rd_ptr[AW-1:0] + AW'(g)];
    end

`ifdef MPCB_ERR_EN
    logic ovf_q;
    logic udf_q;

    // Sticky until reset; flush deliberately leaves them alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if ((bus.wr_num != '0) && !wr_ok) begin
                ovf_q <= 1'b1;
            end
            if (rd_num_x > cnt) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign bus.overflow_err  = ovf_q;
    assign bus.underflow_err = udf_q;
`endif
endmodule

// File: tb/tb_multi_port_circular_buffer.sv
module tb_multi_port_circular_buffer;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;

    multi_port_circular_buffer_if #(
        .T(logic [31:0]), .DEPTH(DEPTH), .WRITE_PORTS(2), .READ_PORTS(2)
    ) bus ();

    multi_port_circular_buffer #(
        .T(logic [31:0]), .DEPTH(DEPTH), .WRITE_PORTS(2), .READ_PORTS(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cnt;
        bit          acc;
        int          popped;
        logic [1:0]  vld;
        logic [31:0] d [2];
        bit          oerr;
        bit          uerr;
    } exp_t;

    exp_t        exp_q [$];
    logic [31:0] model [$];
    bit          oerr_m;
    bit          uerr_m;
    int          checks;
    int          passes;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: compares the DUT against the oldest pending expectation each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("count",      32'(bus.count),      32'(e.cnt));
                chk("free_slots", 32'(bus.free_slots), 32'(DEPTH - e.cnt));
                chk("full",       32'(bus.full),       32'(e.cnt == DEPTH));
                chk("empty",      32'(bus.empty),      32'(e.cnt == 0));
                chk("wr_accept",  32'(bus.wr_accept),  32'(e.acc));
                chk("rd_popped",  32'(bus.rd_popped),  32'(e.popped));
                chk("rd_valid",   32'(bus.rd_valid),   32'(e.vld));
                for (int i = 0; i < 2; i++)
                    if (e.vld[i]) chk($sformatf("rd_data[%0d]", i), bus.rd_data[i], e.d[i]);
`ifdef MPCB_ERR_EN
                chk("overflow_err",  32'(bus.overflow_err),  32'(e.oerr));
                chk("underflow_err", 32'(bus.underflow_err), 32'(e.uerr));
`endif
            end
        end
    end

    // Drive one cycle, record what the queue should show this cycle, then advance the model.
    task automatic step(input bit rs, input bit fl, input int wn, input int rn);
        exp_t        e;
        logic [31:0] d [2];
        int          cnt;
        d[0] = $urandom;
        d[1] = $urandom;
        reset       = rs;
        bus.flush   = fl;
        bus.wr_num  = 2'(wn);
        bus.rd_num  = 2'(rn);
        bus.wr_data = {d[1], d[0]};

        cnt      = model.size();
        e.cnt    = cnt;
        e.acc    = (DEPTH - cnt) >= wn;
        e.popped = (rn < cnt) ? rn : cnt;
        for (int i = 0; i < 2; i++) begin
            e.vld[i] = (i < cnt);
            e.d[i]   = (i < cnt) ? model[i] : 32'h0;
        end
        e.oerr = oerr_m;
        e.uerr = uerr_m;
        exp_q.push_back(e);

        if (rs) begin
            model.delete();
            oerr_m = 1'b0;
            uerr_m = 1'b0;
        end else begin
            if (wn > 0 && !e.acc) oerr_m = 1'b1;
            if (rn > cnt) uerr_m = 1'b1;
            if (fl) model.delete();
            else begin
                for (int i = 0; i < e.popped; i++) void'(model.pop_front());
                if (e.acc) for (int i = 0; i < wn; i++) model.push_back(d[i]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        oerr_m = 1'b0;
        uerr_m = 1'b0;
        reset       = 1'b1;
        bus.flush   = 1'b0;
        bus.wr_num  = '0;
        bus.rd_num  = '0;
        bus.wr_data = '0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state, then basic push/pop.
        step(0, 0, 2, 0);
        step(0, 0, 0, 2);
        step(0, 0, 0, 0);

        // Fill, then full with push+pop offered: write rejected, pop proceeds.
        for (int i = 0; i < 8; i++) step(0, 0, 2, 0);
        step(0, 0, 1, 1);
        // Partial rejection at count 15, then single push fills it.
        step(0, 0, 2, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Drain, then over-pop with one entry.
        for (int i = 0; i < 8; i++) step(0, 0, 0, 2);
        step(0, 0, 1, 0);
        step(0, 0, 0, 2);
        step(0, 0, 0, 0);

        // Flush with same-cycle push/pop at count 7.
        for (int i = 0; i < 3; i++) step(0, 0, 2, 0);
        step(0, 0, 1, 0);
        step(0, 1, 2, 2);
        step(0, 0, 0, 0);

        // Wrap-around: move pointers to 15, then push two that straddle the array end.
        for (int i = 0; i < 7; i++) step(0, 0, 2, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 2);
        step(0, 0, 0, 1);
        step(0, 0, 2, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Mixed random traffic with occasional flushes.
        for (int i = 0; i < 64; i++)
            step(0, ($urandom_range(0, 15) == 0), $urandom_range(0, 2), $urandom_range(0, 2));
        for (int i = 0; i < 16; i++)
            step(0, 0, $urandom_range(1, 2), $urandom_range(0, 1));

        // Reset in the middle of a burst.
        step(1, 0, 2, 1);
        step(0, 0, 0, 0);
        step(0, 0, 2, 2);
        step(0, 0, 0, 2);

        bus.wr_num = '0;
        bus.rd_num = '0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/multi_port_circular_buffer.md
Name: multi_port_circular_buffer

Overview:
- Parametrised in-order circular queue with WRITE_PORTS enqueue lanes and READ_PORTS dequeue lanes per cycle.
- Serves as the superscalar fetch/decode and dispatch queue in the OoO core.
- Adds to the single-port buffer:
  - multi-entry push/pop per cycle;
  - all-or-nothing write acceptance;
  - occupancy outputs;
  - a flush for branch mispredict recovery.

Parameters:
- T, logic [31:0], entry type.
- DEPTH, 16, number of entries; power of two, at least 2, and at least max(WRITE_PORTS, READ_PORTS).
- WRITE_PORTS, 2, maximum entries enqueued per cycle.
- READ_PORTS, 2, maximum entries dequeued per cycle.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  discard all contents.
- wr_num  input  $clog2(WRITE_PORTS+1)  entries offered this cycle, lanes 0..wr_num-1.
- wr_data  input  T[WRITE_PORTS]  lane data; lane 0 is oldest.
- wr_accept  output  1  offered group accepted this cycle.
- rd_num  input  $clog2(READ_PORTS+1)  entries requested to pop.
- rd_data  output  T[READ_PORTS]  oldest entries; lane 0 is the head.
- rd_valid  output  READ_PORTS  rd_valid[i] = (i < count).
- rd_popped  output  $clog2(READ_PORTS+1)  entries actually popped = min(rd_num, count).
- count  output  $clog2(DEPTH)+1  current occupancy.
- free_slots  output  $clog2(DEPTH)+1  DEPTH - count.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.

Behaviour:
- Storage and pointers:
  - Storage is an array of DEPTH entries of T.
  - rd_ptr and wr_ptr are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - count = wr_ptr - rd_ptr, modulo 2^($clog2(DEPTH)+1).
- Reset (synchronous):
  - rd_ptr = wr_ptr = 0.
  - Outputs after reset: count=0, free_slots=DEPTH, empty=1, full=0, rd_valid=0, rd_popped=0.
  - Storage contents are not reset; rd_data is don't-care where rd_valid=0.
- Write:
  - wr_accept = (free_slots >= wr_num), computed from registered state only. It is combinational with no dependence on rd_num, so there is no same-cycle read credit.
  - wr_num=0 gives wr_accept=1 with no effect.
  - On the clock edge with wr_accept and !flush, lane i writes storage[(wr_ptr+i) mod DEPTH] for i < wr_num, and wr_ptr += wr_num.
  - Partial acceptance is never allowed: when wr_accept=0, nothing is written and wr_ptr is unchanged.
- Read:
  - rd_data[i] = storage[(rd_ptr+i) mod DEPTH]. This is combinational from registered state, so data is visible in the cycle after its write (one-cycle write-to-read latency, no bypass).
  - On the clock edge with !flush, rd_ptr += rd_popped.
  - Popping more than count saturates at count; requesting a pop while empty is a legal no-op.
- Simultaneous read and write:
  - Both apply in the same cycle; the new count = count + accepted wr_num - rd_popped.
  - A full queue with rd_num=2 and wr_num=2 rejects the write in that cycle.
- Wrap-around: indices wrap modulo DEPTH across the array end within a single multi-lane operation. The pointer MSB toggles on each wrap.
- Flush:
  - In the next cycle rd_ptr = wr_ptr = 0, and the effect is identical to reset.
  - Flush has priority over same-cycle writes and pops. wr_accept may still read 1, but the write is discarded.
- Reset mid-operation: any in-flight operation is discarded; reset has priority over flush.
- full and empty are derived from count.

Optional Feature:
- Macro: MPCB_ERR_EN.
- When defined:
  - Adds output `overflow_err` (1 bit): sticky, set when wr_num > 0 && !wr_accept.
  - Adds output `underflow_err` (1 bit): sticky, set when rd_num > count.
  - Both flags clear only on reset; flush does not clear them.
  - Both flags are registered and assert the cycle after the offending cycle.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Basic push/pop:
  - Stimulus: after reset, wr_num=2, data {A0,A1}.
  - Required: next cycle count=2, rd_valid=2'b11, rd_data={A0,A1}.
  - Then rd_num=2 → empty=1 the following cycle.
- Fill and reject (DEPTH=16):
  - Stimulus: push 2 per cycle for 8 cycles.
  - Required: full=1, free_slots=0.
  - Then wr_num=1 with rd_num=1 → wr_accept=0, count=15 next cycle, the rejected data is absent, and order is preserved.
- Partial rejection:
  - Stimulus: count=15, wr_num=2.
  - Required: wr_accept=0, count stays 15; overflow_err=1 next cycle if MPCB_ERR_EN.
  - Then wr_num=1 → accepted, count=16.
- Wrap-around:
  - Stimulus: bring rd_ptr to 15, then push {B0,B1}, which land in slots 15 and 0.
  - Required: rd_data={B0,B1} in order, and the wrap bit toggles.
  - Exercise 64 mixed random-count cycles against a reference queue model.
- Over-pop:
  - Stimulus: count=1, rd_num=2.
  - Required: rd_popped=1, rd_valid=2'b01, empty=1 next cycle; underflow_err=1 if MPCB_ERR_EN.
- Flush priority:
  - Stimulus: count=7, assert flush with wr_num=2 and rd_num=2 in the same cycle.
  - Required: next cycle count=0, empty=1, the write is discarded, and the error flags are unchanged.
  - Reset asserted mid-burst → the same empty state.
